// File: rtl/seq_div_nbit.sv
// seq_div_nbit - multi-cycle restoring integer divider, one quotient bit per clock.
//
// Computes quotient and remainder of dividend / divisor in unsigned or
// two's-complement mode (truncation toward zero, remainder takes the sign of
// the dividend). A zero divisor yields quotient = all ones, remainder = the
// dividend as given, and raises div_by_zero.
//
// Ports
//   clk          system clock, rising edge
//   clr          synchronous active-high reset, overrides everything
//   start        request a division, sampled only while idle
//   signed_mode  1 = two's-complement operands (ignored when SIGNED_EN = 0)
//   dividend     numerator, latched with start
//   divisor      denominator, latched with start
//   busy         high while an operation is in progress
//   done         one-cycle pulse when results are valid
//   quotient     result quotient, held until the next result is written
//   remainder    result remainder, held until the next result is written
//   div_by_zero  set with done when the divisor was zero, cleared by next start
//
// state | meaning
// IDLE  | waiting for start
// PREP  | zero-divisor check, operand magnitudes, result signs, counter load
// RUN   | one shift/trial-subtract step per cycle, WIDTH cycles
// FIX   | apply result signs (or zero-divide result) and write outputs
// DONE  | done pulse, back to IDLE

module seq_div_nbit #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state;
  logic [WIDTH-1:0] acc;       // dividend going in, quotient bits shifting in
  logic [WIDTH-1:0] part_rem;  // partial remainder
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             mode;
  logic             neg_quo;
  logic             neg_rem;
  logic             zero_div;

  logic             use_sign;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fit;

  assign use_sign = SIGNED_EN && mode;

  // Negating the most negative value gives the same bit pattern, which read
  // as unsigned is exactly its magnitude 2^(WIDTH-1).
  assign dvd_abs = (use_sign && acc[WIDTH-1]) ? -acc : acc;
  assign dvs_abs = (use_sign && dvs[WIDTH-1]) ? -dvs : dvs;
  assign quo_fix = neg_quo ? -acc : acc;
  assign rem_fix = neg_rem ? -part_rem : part_rem;

  // The partial remainder is always below the divisor, so when the shifted-out
  // top bit is set the shifted value exceeds the divisor and the subtract must
  // succeed; the low WIDTH bits of the difference are then still exact.
  assign shifted = {part_rem, acc[WIDTH-1]};
  assign trial   = {1'b0, shifted[WIDTH-1:0]} - {1'b0, dvs};
  assign fit     = shifted[WIDTH] | ~trial[WIDTH];

  assign busy = (state == S_PREP) || (state == S_RUN) || (state == S_FIX);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= S_IDLE;
      acc         <= '0;
      part_rem    <= '0;
      dvs         <= '0;
      cnt         <= '0;
      mode        <= 1'b0;
      neg_quo     <= 1'b0;
      neg_rem     <= 1'b0;
      zero_div    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc         <= dividend;
            dvs         <= divisor;
            mode        <= SIGNED_EN ? signed_mode : 1'b0;
            div_by_zero <= 1'b0;
            state       <= S_PREP;
          end
        end
        S_PREP: begin
          if (dvs == '0) begin
            // acc keeps the raw dividend for the zero-divide remainder
            zero_div <= 1'b1;
            state    <= S_FIX;
          end else begin
            zero_div <= 1'b0;
            acc      <= dvd_abs;
            dvs      <= dvs_abs;
            neg_quo  <= use_sign && (acc[WIDTH-1] ^ dvs[WIDTH-1]);
            neg_rem  <= use_sign && acc[WIDTH-1];
            part_rem <= '0;
            cnt      <= CW'(WIDTH);
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          part_rem <= fit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          acc      <= {acc[WIDTH-2:0], fit};
          cnt      <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          if (zero_div) begin
            quotient    <= '1;
            remainder   <= acc;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= quo_fix;
            remainder   <= rem_fix;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_nbit.sv
// Testbench for seq_div_nbit: a 32-bit and an 8-bit instance share clock and
// clear. A cycle-level reference model (arithmetic division plus start/done
// timing) is compared against both instances every cycle; directed operations
// are also checked against hand-computed literals.

module tb_seq_div_nbit;

  logic        clk = 1'b0;
  logic        clr;
  logic [1:0]  start_v, sm_v, busy_v, done_v, dbz_v;
  logic [31:0] dvd32, dvs32, q32, r32;
  logic [7:0]  dvd8, dvs8, q8, r8;

  always #5 clk = ~clk;

  seq_div_nbit #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
    .clk(clk), .clr(clr), .start(start_v[0]), .signed_mode(sm_v[0]),
    .dividend(dvd32), .divisor(dvs32), .busy(busy_v[0]), .done(done_v[0]),
    .quotient(q32), .remainder(r32), .div_by_zero(dbz_v[0])
  );

  seq_div_nbit #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
    .clk(clk), .clr(clr), .start(start_v[1]), .signed_mode(sm_v[1]),
    .dividend(dvd8), .divisor(dvs8), .busy(busy_v[1]), .done(done_v[1]),
    .quotient(q8), .remainder(r8), .div_by_zero(dbz_v[1])
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int s_edge = 0;
  bit model_on = 1'b0;

  // reference model state per instance
  bit          act [2];
  int          d_e [2];
  logic [31:0] eq [2], er [2], hq [2], hr [2];
  bit          ez [2], hz [2];

  function automatic int wid(input int i);
    return (i == 0) ? 32 : 8;
  endfunction

  function automatic logic [31:0] get_q(input int i);
    return (i == 0) ? q32 : {24'h0, q8};
  endfunction

  function automatic logic [31:0] get_r(input int i);
    return (i == 0) ? r32 : {24'h0, r8};
  endfunction

  function automatic logic [31:0] get_dvd(input int i);
    return (i == 0) ? dvd32 : {24'h0, dvd8};
  endfunction

  function automatic logic [31:0] get_dvs(input int i);
    return (i == 0) ? dvs32 : {24'h0, dvs8};
  endfunction

  // Plain arithmetic: SV integer division truncates toward zero and % takes
  // the dividend's sign, which is exactly the required signed behaviour.
  function automatic void model_div(input int w, input logic [31:0] a,
                                    input logic [31:0] b, input bit sm,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output bit z);
    longint m, sa, sb, lq, lr;
    m  = (longint'(1) << w) - 1;
    sa = longint'(a) & m;
    sb = longint'(b) & m;
    if (sb == 0) begin
      lq = m;
      lr = sa;
      z  = 1'b1;
    end else begin
      if (sm) begin
        if (sa[w-1]) sa = sa - (longint'(1) << w);
        if (sb[w-1]) sb = sb - (longint'(1) << w);
      end
      lq = sa / sb;
      lr = sa % sb;
      z  = 1'b0;
    end
    lq = lq & m;
    lr = lr & m;
    q  = lq[31:0];
    r  = lr[31:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act_v, exp_v, cyc);
    end
  endtask

  // model update at each rising edge, comparison on the following falling edge
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (clr) begin
          act[i] = 1'b0;
          hq[i]  = '0;
          hr[i]  = '0;
          hz[i]  = 1'b0;
          model_on = 1'b1;
        end else begin
          if (act[i] && cyc == d_e[i]) begin
            hq[i] = eq[i];
            hr[i] = er[i];
            hz[i] = ez[i];
          end
          if (start_v[i] && (!act[i] || cyc >= d_e[i] + 2)) begin
            model_div(wid(i), get_dvd(i), get_dvs(i), sm_v[i], eq[i], er[i], ez[i]);
            d_e[i] = cyc + (ez[i] ? 2 : wid(i) + 2);
            act[i] = 1'b1;
            hz[i]  = 1'b0;
          end
        end
      end
      @(negedge clk);
      if (model_on) begin
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("m%0d_busy", i), {31'h0, busy_v[i]}, {31'h0, act[i] && cyc < d_e[i]});
          chk($sformatf("m%0d_done", i), {31'h0, done_v[i]}, {31'h0, act[i] && cyc == d_e[i]});
          chk($sformatf("m%0d_quotient", i), get_q(i), hq[i]);
          chk($sformatf("m%0d_remainder", i), get_r(i), hr[i]);
          chk($sformatf("m%0d_dbz", i), {31'h0, dbz_v[i]}, {31'h0, hz[i]});
        end
      end
    end
  end

  task automatic do_start(input int i, input logic [31:0] a, input logic [31:0] b, input bit sm);
    @(negedge clk);
    if (i == 0) begin
      dvd32 = a;
      dvs32 = b;
    end else begin
      dvd8 = a[7:0];
      dvs8 = b[7:0];
    end
    sm_v[i]    = sm;
    start_v[i] = 1'b1;
    s_edge     = cyc + 1;
    @(negedge clk);
    start_v[i] = 1'b0;
    // operands are free to change once start has been sampled
    dvd32 = $urandom;
    dvs32 = $urandom;
    dvd8  = 8'($urandom);
    dvs8  = 8'($urandom);
    sm_v  = 2'($urandom);
  endtask

  task automatic wait_done(input int i, input int lat, input logic [31:0] xq,
                           input logic [31:0] xr, input bit xz, input string nm);
    bit seen = 1'b0;
    for (int n = 0; n < 80 && !seen; n++) begin
      if (done_v[i]) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done, expected done within 80 cycles", nm);
    end else begin
      chk({nm, "_latency"}, 32'(cyc - s_edge), 32'(lat));
      chk({nm, "_quotient"}, get_q(i), xq);
      chk({nm, "_remainder"}, get_r(i), xr);
      chk({nm, "_dbz"}, {31'h0, dbz_v[i]}, {31'h0, xz});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish before 100us");
    $fatal(1, "timeout");
  end

  initial begin
    int k5;
    int quiet;
    clr = 1'b1;
    start_v = '0;
    sm_v = '0;
    dvd32 = '0; dvs32 = '0; dvd8 = '0; dvs8 = '0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    chk("reset_busy", {31'h0, busy_v[0]}, 32'h0);
    chk("reset_done", {31'h0, done_v[0]}, 32'h0);
    chk("reset_quotient", q32, 32'h0);
    chk("reset_remainder", r32, 32'h0);

    // unsigned basic
    do_start(0, 32'd100, 32'd10, 1'b0);
    wait_done(0, 34, 32'd10, 32'd0, 1'b0, "t1_u100_10");

    // signed vs unsigned on the same bits, plus the other sign combinations
    do_start(0, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(0, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "t2_s_m7_2");
    do_start(0, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done(0, 34, 32'h7FFF_FFFC, 32'h1, 1'b0, "t2_u_m7_2");
    do_start(0, 32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_done(0, 34, 32'hFFFF_FFFD, 32'h1, 1'b0, "t2_s_7_m2");
    do_start(0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1);
    wait_done(0, 34, 32'h3, 32'hFFFF_FFFF, 1'b0, "t2_s_m7_m2");

    // divide by zero, flag cleared by the next accepted start
    do_start(0, 32'd5, 32'd0, 1'b0);
    wait_done(0, 2, 32'hFFFF_FFFF, 32'd5, 1'b1, "t3_u5_0");
    do_start(0, 32'd12, 32'd4, 1'b0);
    chk("t3_flag_clear", {31'h0, dbz_v[0]}, 32'h0);
    wait_done(0, 34, 32'd3, 32'd0, 1'b0, "t3_u12_4");
    do_start(0, 32'hFFFF_FFFB, 32'd0, 1'b1);
    wait_done(0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, "t3_s_m5_0");

    // overflow and large unsigned
    do_start(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(0, 34, 32'h8000_0000, 32'h0, 1'b0, "t4_s_ovf");
    do_start(0, 32'hFFFF_FFFF, 32'h10, 1'b0);
    wait_done(0, 34, 32'h0FFF_FFFF, 32'hF, 1'b0, "t4_u_max_16");

    // ignored start while busy, then clear mid-operation
    do_start(0, 32'd100, 32'd10, 1'b0);
    k5 = s_edge;
    while (cyc < k5 + 4) @(negedge clk);
    dvd32 = 32'd9;
    dvs32 = 32'd3;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    while (cyc < k5 + 9) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t5_clr_busy", {31'h0, busy_v[0]}, 32'h0);
    chk("t5_clr_quotient", q32, 32'h0);
    chk("t5_clr_remainder", r32, 32'h0);
    quiet = 0;
    for (int n = 0; n < 40; n++) begin
      if (done_v[0]) quiet++;
      @(negedge clk);
    end
    chk("t5_no_done_after_clr", 32'(quiet), 32'h0);
    do_start(0, 32'd9, 32'd3, 1'b0);
    wait_done(0, 34, 32'd3, 32'd0, 1'b0, "t5_u9_3");

    // 8-bit instance, including a back-to-back start right after done
    do_start(1, 32'd200, 32'd7, 1'b0);
    wait_done(1, 10, 32'd28, 32'd4, 1'b0, "t6_u200_7");
    do_start(1, 32'd255, 32'd16, 1'b0);
    wait_done(1, 10, 32'd15, 32'd15, 1'b0, "t6_b2b_u255_16");
    do_start(1, 32'h80, 32'hFF, 1'b1);
    wait_done(1, 10, 32'h80, 32'h0, 1'b0, "t6_s_ovf8");
    do_start(1, 32'h9C, 32'd7, 1'b1);
    wait_done(1, 10, 32'hF2, 32'hFE, 1'b0, "t6_s_m100_7");
    do_start(1, 32'h9C, 32'd0, 1'b1);
    wait_done(1, 2, 32'hFF, 32'h9C, 1'b1, "t6_s_zero8");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
